rx_packet_counter: RTL
======================

RX_PACKET_COUNTER -- requirements
Module: rx_packet_counter

Interface
REQ-001 Parameter BITS_PER_BYTE, default 8: number of counted bit strobes that make one byte; legal range 2..16.
REQ-002 Parameter MAX_BYTES, default 64: maximum packet length in bytes; legal range 1..1023.
REQ-003 Parameter BYTE_CNT_W, default $clog2(MAX_BYTES+1): width of byte_count.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port clear, input, 1: start-of-packet or end-of-packet synchronous clear of all counting state.
REQ-007 Port shift_enable, input, 1: one-cycle strobe marking one received, decoded bit.
REQ-008 Port stuff_bit, input, 1: qualifies shift_enable; the strobed bit is a stuffed bit and is not counted.
REQ-009 Port bit_count, output, $clog2(BITS_PER_BYTE): bits counted in the current byte.
REQ-010 Port byte_count, output, BYTE_CNT_W: completed bytes in the current packet.
REQ-011 Port byte_done, output, 1: registered one-cycle pulse per completed byte.
REQ-012 Port packet_full, output, 1: high while byte_count == MAX_BYTES.
REQ-013 Port overflow, output, 1: sticky flag; a byte completed while packet_full was high.

Function
REQ-014 Counted strobe: shift_enable=1 and stuff_bit=0 and clear=0.
REQ-015 On a counted strobe with bit_count < BITS_PER_BYTE-1, bit_count increments by 1.
REQ-016 On a counted strobe with bit_count == BITS_PER_BYTE-1:
- bit_count wraps to 0.
- byte_done is 1 in the following cycle only.
REQ-017 On the byte completion of REQ-016 with packet_full=0, byte_count increments by 1 in the same edge.
REQ-018 On the byte completion of REQ-016 with packet_full=1:
- byte_count holds at MAX_BYTES (saturating).
- overflow sets to 1.
- byte_done still pulses.
REQ-019 overflow, once set, stays 1 until clear or rst.
REQ-020 shift_enable=1 with stuff_bit=1 changes no state; byte_done=0 in the next cycle.
REQ-021 shift_enable=0 holds all counters; stuff_bit is ignored while shift_enable=0.
REQ-022 clear=1, on the next edge:
- bit_count, byte_count, overflow and byte_done all go to 0.
- clear takes priority over a simultaneous shift_enable.
REQ-023 Back-to-back counted strobes on consecutive cycles are supported with no lost bits; byte_done never stays high for two consecutive cycles when BITS_PER_BYTE >= 2.
REQ-024 packet_full is combinational from byte_count; all other outputs are registered.

Reset
REQ-025 rst=1, on the next edge: bit_count=0, byte_count=0, byte_done=0, overflow=0, and therefore packet_full=0.
REQ-026 rst has priority over clear and shift_enable.
REQ-027 rst asserted mid-byte or mid-packet discards the partial count; counting restarts from 0 after rst deasserts.

Structure
REQ-028 A shared package rx_pkg holds:
- the USB full-speed default constants USB_BITS_PER_BYTE=8 and USB_MAX_PKT_BYTES=64;
- the packet-counter status struct {byte_done, packet_full, overflow} for consumers in the RX datapath.
REQ-029 The bit counter is one instance of the existing flex_counter sub-module, with rollover_val set to BITS_PER_BYTE and its count_enable driven by the counted-strobe term.
REQ-030 Byte count, saturation, overflow and the byte_done register are local logic in rx_packet_counter.
REQ-031 No other sub-modules are used.

Verification (defaults: BITS_PER_BYTE=8, MAX_BYTES=64)
REQ-032 Reset then 8 consecutive counted strobes:
- byte_done=1 for exactly one cycle, in the cycle after the 8th strobe.
- bit_count=0 and byte_count=1 after the 8th strobe.
REQ-033 Eight counted strobes interleaved with 3 stuff_bit strobes: byte completes only after the 8th counted strobe; byte_count=1.
REQ-034 512 counted strobes, then 8 more:
- after 512, byte_count=64 and packet_full=1;
- after 8 more, byte_count=64, overflow=1, and byte_done pulses.
REQ-035 5 counted strobes, then clear asserted together with a strobe:
- next cycle bit_count=0 and byte_count=0.
- no byte_done.
REQ-036 rst asserted after 3 bytes plus 4 bits, then 8 strobes: all outputs are 0 after rst; byte_count=1 after the 8 strobes.
REQ-037 Parameter sweep with BITS_PER_BYTE=4 and MAX_BYTES=2:
- overflow sets on the 12th counted strobe.
- byte_count saturates at 2.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and status types for the USB receive datapath.
package rx_pkg;

  localparam int USB_BITS_PER_BYTE = 8;
  localparam int USB_MAX_PKT_BYTES = 64;

  // Packet-counter status as seen by downstream RX consumers.
  typedef struct packed {
    logic byte_done;
    logic packet_full;
    logic overflow;
  } pkt_cnt_status_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter that runs 0..rollover_val-1 and wraps to 0.
// `rollover` flags the enabled cycle on which the wrap happens.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS:0]   rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover
);

  logic [NUM_CNT_BITS:0] last_val;
  logic                  at_last;

  // rollover_val is one bit wider so a full power-of-two range is expressible.
  assign last_val = rollover_val - (NUM_CNT_BITS+1)'(1);
  assign at_last  = ({1'b0, count_out} == last_val);
  assign rollover = count_enable && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (at_last) begin
        count_out <= '0;
      end else begin
        count_out <= count_out + NUM_CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/rx_packet_counter.sv
// Counts decoded, non-stuffed bits into bytes and bytes into a packet,
// saturating at MAX_BYTES and flagging any byte that arrives past that.
module rx_packet_counter
  import rx_pkg::*;
#(
  parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
  parameter int MAX_BYTES     = USB_MAX_PKT_BYTES,
  parameter int BYTE_CNT_W    = $clog2(MAX_BYTES+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             shift_enable,
  input  logic                             stuff_bit,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_count,
  output logic [BYTE_CNT_W-1:0]            byte_count,
  output logic                             byte_done,
  output logic                             packet_full,
  output logic                             overflow
);

  localparam int BIT_CNT_W = $clog2(BITS_PER_BYTE);
  localparam logic [BIT_CNT_W:0]    ROLL_VAL = (BIT_CNT_W+1)'(BITS_PER_BYTE);
  localparam logic [BYTE_CNT_W-1:0] MAX_CNT  = BYTE_CNT_W'(MAX_BYTES);

  logic counted;
  logic byte_wrap;

  // shift_enable is a bare one-cycle strobe with no back-pressure; a stuffed
  // bit or a concurrent clear makes the strobe a no-op for counting.
  assign counted = shift_enable && !stuff_bit && !clear;

  flex_counter #(
    .NUM_CNT_BITS (BIT_CNT_W)
  ) u_bit_counter (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (counted),
    .rollover_val (ROLL_VAL),
    .count_out    (bit_count),
    .rollover     (byte_wrap)
  );

  assign packet_full = (byte_count == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count <= '0;
      byte_done  <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      byte_count <= '0;
      byte_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      byte_done <= byte_wrap;
      if (byte_wrap) begin
        if (packet_full) begin
          overflow <= 1'b1;
        end else begin
          byte_count <= byte_count + BYTE_CNT_W'(1);
        end
      end
    end
  end

endmodule
